// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions,
// active-high glyph patterns and the pin polarity helper.
package seg7_pkg;

  localparam int SEG_W = 7;

  // Segment bit positions inside a glyph (bit 0 = a ... bit 6 = g).
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef logic [SEG_W-1:0] glyph_t;

  // Glyphs are active-high (1 = segment lit), written as gfedcba.
  localparam glyph_t GLYPH_0     = 7'b0111111;
  localparam glyph_t GLYPH_1     = 7'b0000110;
  localparam glyph_t GLYPH_2     = 7'b1011011;
  localparam glyph_t GLYPH_3     = 7'b1001111;
  localparam glyph_t GLYPH_4     = 7'b1100110;
  localparam glyph_t GLYPH_5     = 7'b1101101;
  localparam glyph_t GLYPH_6     = 7'b1111101;
  localparam glyph_t GLYPH_7     = 7'b0000111;
  localparam glyph_t GLYPH_8     = 7'b1111111;
  localparam glyph_t GLYPH_9     = 7'b1101111;
  localparam glyph_t GLYPH_A     = 7'b1110111;
  localparam glyph_t GLYPH_B     = 7'b1111100;
  localparam glyph_t GLYPH_C     = 7'b0111001;
  localparam glyph_t GLYPH_D     = 7'b1011110;
  localparam glyph_t GLYPH_E     = 7'b1111001;
  localparam glyph_t GLYPH_F     = 7'b1110001;
  localparam glyph_t GLYPH_BLANK = 7'b0000000;

  // Convert an internal active-high glyph to pin level.
  function automatic glyph_t apply_polarity(input glyph_t g, input logic active_low);
    return active_low ? ~g : g;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load port of the scan driver: one full display word per transfer.
//
// Handshake: a word transfers on a rising clk edge where load_valid and
// load_ready are both 1. The source holds load_valid/load_bcd/load_dp stable
// while load_ready is 0; load_ready does not depend on load_valid.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load_valid;
  logic                      load_ready;
  logic [4*NUM_DIGITS-1:0]   load_bcd;
  logic [NUM_DIGITS-1:0]     load_dp;

  modport master (output load_valid, output load_bcd, output load_dp, input load_ready);
  modport slave  (input load_valid, input load_bcd, input load_dp, output load_ready);
endinterface

// File: rtl/seg7_digit_decode.sv
// Combinational 4-bit code to active-high 7-segment glyph.
// Codes 10-15 show A,b,C,d,E,F when hex mode is on, otherwise blank.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic   [3:0] i_code,
  input  logic         i_hex_mode,
  output glyph_t       o_glyph
);

  // Glyph lookup; everything not explicitly listed stays blank.
  always_comb begin
    o_glyph = GLYPH_BLANK;
    case (i_code)
      4'd0:  o_glyph = GLYPH_0;
      4'd1:  o_glyph = GLYPH_1;
      4'd2:  o_glyph = GLYPH_2;
      4'd3:  o_glyph = GLYPH_3;
      4'd4:  o_glyph = GLYPH_4;
      4'd5:  o_glyph = GLYPH_5;
      4'd6:  o_glyph = GLYPH_6;
      4'd7:  o_glyph = GLYPH_7;
      4'd8:  o_glyph = GLYPH_8;
      4'd9:  o_glyph = GLYPH_9;
      4'd10: o_glyph = i_hex_mode ? GLYPH_A : GLYPH_BLANK;
      4'd11: o_glyph = i_hex_mode ? GLYPH_B : GLYPH_BLANK;
      4'd12: o_glyph = i_hex_mode ? GLYPH_C : GLYPH_BLANK;
      4'd13: o_glyph = i_hex_mode ? GLYPH_D : GLYPH_BLANK;
      4'd14: o_glyph = i_hex_mode ? GLYPH_E : GLYPH_BLANK;
      4'd15: o_glyph = i_hex_mode ? GLYPH_F : GLYPH_BLANK;
      default: o_glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment driver. A display word is accepted into a
// shadow register and copied to the live display only at a frame boundary,
// so one frame never mixes two words. Digits are scanned round-robin with a
// dark guard interval at the start of every slot to stop ghosting.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int GUARD      = 2,
  parameter int HEX_MODE   = 0,
  parameter int LZ_BLANK   = 1,
  parameter int ACTIVE_LOW = 1
)(
  input  logic                   clk,
  input  logic                   rst,
  seg7_scan_driver_if.slave      load_if,
  input  logic                   enable,
  output logic [SEG_W-1:0]       seg,
  output logic                   dp,
  output logic [NUM_DIGITS-1:0]  an,
  output logic                   frame_tick
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             POL_LOW  = (ACTIVE_LOW != 0);

  // Inactive pin levels.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = POL_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [SEG_W-1:0]      SEG_OFF = POL_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic                  DP_OFF  = POL_LOW;

  logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_disp_bcd;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [DIV_W-1:0]        r_div;
  logic [IDX_W-1:0]        r_idx;
  logic [SEG_W-1:0]        r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_slot_end;
  logic                    w_wrap;
  logic                    w_accept;
  logic                    w_commit;
  logic [3:0]              w_code;
  logic                    w_dp_bit;
  logic                    w_blank;
  logic                    w_zero_run;
  logic                    w_guard_ok;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_onehot;
  glyph_t                  w_glyph;

  assign w_slot_end = (r_div == DIV_LAST);
  // Frame boundary: the last cycle of the last digit slot, while scanning.
  assign w_wrap     = enable & w_slot_end & (r_idx == IDX_LAST);
  assign w_accept   = load_if.load_valid & ~r_pending;
  // Never coincides with w_accept: one needs pending=0, the other pending=1.
  assign w_commit   = w_wrap & r_pending;

  assign load_if.load_ready = ~r_pending;
  assign frame_tick         = w_wrap;

  // Accept a word into the shadow register; move it to the display at a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow_bcd <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
      r_disp_bcd   <= '0;
      r_disp_dp    <= '0;
    end else if (w_accept) begin
      r_shadow_bcd <= load_if.load_bcd;
      r_shadow_dp  <= load_if.load_dp;
      r_pending    <= 1'b1;
    end else if (w_commit) begin
      r_disp_bcd   <= r_shadow_bcd;
      r_disp_dp    <= r_shadow_dp;
      r_pending    <= 1'b0;
    end
  end

  // Slot divider and digit index; both freeze while the display is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (enable) begin
      if (w_slot_end) begin
        r_div <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // Select the current digit and decide leading-zero blanking, scanning from the top digit down.
  always_comb begin
    w_code     = 4'd0;
    w_dp_bit   = 1'b0;
    w_blank    = 1'b0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_disp_bcd[4*i +: 4] == 4'd0) & ~r_disp_dp[i];
      if (r_idx == IDX_W'(i)) begin
        w_code   = r_disp_bcd[4*i +: 4];
        w_dp_bit = r_disp_dp[i];
        w_blank  = (LZ_BLANK != 0) && (i > 0) && w_zero_run;
      end
    end
  end

  assign w_guard_ok = (int'(r_div) >= GUARD);
  assign w_lit      = enable & w_guard_ok & ~w_blank;
  assign w_onehot   = NUM_DIGITS'(1) << r_idx;

  seg7_digit_decode u_decode (
    .i_code     (w_code),
    .i_hex_mode (HEX_MODE != 0),
    .o_glyph    (w_glyph)
  );

  // Registered pin stage: drive the selected digit or hold every pin inactive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
    end else if (w_lit) begin
      r_an  <= POL_LOW ? ~w_onehot : w_onehot;
      r_seg <= apply_polarity(w_glyph, POL_LOW);
      r_dp  <= w_dp_bit ^ POL_LOW;
    end else begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (decimal and hex glyphs) share one
// stimulus stream. A reference model tracks the scan as a position within the
// frame and pushes the expected pins per cycle; a monitor pops and compares.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int GD    = 1;
  localparam int FRAME = ND * SD;
  localparam int W     = 7 + 1 + ND + 1 + 1;  // seg | dp | an | ready | frame_tick

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) if_dec ();
  seg7_scan_driver_if #(.NUM_DIGITS(ND)) if_hex ();

  assign if_hex.load_valid = if_dec.load_valid;
  assign if_hex.load_bcd   = if_dec.load_bcd;
  assign if_hex.load_dp    = if_dec.load_dp;

  logic [6:0]    seg_dec, seg_hex;
  logic          dp_dec, dp_hex;
  logic [ND-1:0] an_dec, an_hex;
  logic          ft_dec, ft_hex;

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD), .HEX_MODE(0),
                     .LZ_BLANK(1), .ACTIVE_LOW(1)) u_dut_dec (
    .clk(clk), .rst(rst), .load_if(if_dec), .enable(enable),
    .seg(seg_dec), .dp(dp_dec), .an(an_dec), .frame_tick(ft_dec)
  );

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD), .HEX_MODE(1),
                     .LZ_BLANK(1), .ACTIVE_LOW(1)) u_dut_hex (
    .clk(clk), .rst(rst), .load_if(if_hex), .enable(enable),
    .seg(seg_hex), .dp(dp_hex), .an(an_hex), .frame_tick(ft_hex)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // Pin patterns at active-low level, written gfedcba, as seen on a common-anode board.
  function automatic logic [6:0] glyph_pins(input int code, input bit hex);
    case (code)
      0: return 7'b1000000;   1: return 7'b1111001;
      2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;
      10: return hex ? 7'b0001000 : 7'b1111111;
      11: return hex ? 7'b0000011 : 7'b1111111;
      12: return hex ? 7'b1000110 : 7'b1111111;
      13: return hex ? 7'b0100001 : 7'b1111111;
      14: return hex ? 7'b0000110 : 7'b1111111;
      default: return hex ? 7'b0001110 : 7'b1111111;
    endcase
  endfunction

  int          m_pos = 0;         // cycle position within the frame: digit*SD + slot cycle
  logic [15:0] m_disp = '0, m_shadow = '0;
  logic [3:0]  m_disp_dp = '0, m_shadow_dp = '0;
  bit          m_pending = 0;

  logic [W-1:0] exp_dec_q[$];
  logic [W-1:0] exp_hex_q[$];

  always @(posedge clk) begin : model
    logic [6:0]    e_seg_dec, e_seg_hex;
    logic          e_dp;
    logic [ND-1:0] e_an;
    int            digit, code;
    bit            lead_zero, boundary;
    e_seg_dec = 7'h7F;
    e_seg_hex = 7'h7F;
    e_dp      = 1'b1;
    e_an      = '1;
    if (rst) begin
      m_pos = 0; m_disp = '0; m_disp_dp = '0;
      m_shadow = '0; m_shadow_dp = '0; m_pending = 0;
    end else begin
      if (enable) begin
        digit = m_pos / SD;
        lead_zero = 1;
        for (int j = digit; j < ND; j++)
          if (((m_disp >> (4*j)) & 16'hF) != 16'h0 || m_disp_dp[j]) lead_zero = 0;
        if ((m_pos % SD) >= GD && !(digit > 0 && lead_zero)) begin
          code      = int'((m_disp >> (4*digit)) & 16'hF);
          e_an      = ~(ND'(1) << digit);
          e_seg_dec = glyph_pins(code, 0);
          e_seg_hex = glyph_pins(code, 1);
          e_dp      = ~m_disp_dp[digit];
        end
      end
      boundary = enable && (m_pos == FRAME - 1);
      if (if_dec.load_valid && !m_pending) begin
        m_shadow = if_dec.load_bcd; m_shadow_dp = if_dec.load_dp; m_pending = 1;
      end else if (boundary && m_pending) begin
        m_disp = m_shadow; m_disp_dp = m_shadow_dp; m_pending = 0;
      end
      if (enable) m_pos = (m_pos + 1) % FRAME;
    end
    exp_dec_q.push_back({e_seg_dec, e_dp, e_an, !m_pending, enable && (m_pos == FRAME - 1)});
    exp_hex_q.push_back({e_seg_hex, e_dp, e_an, !m_pending, enable && (m_pos == FRAME - 1)});
  end

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin : monitor
    logic [W-1:0] exp_v, act_v;
    #1;
    act_v = {seg_dec, dp_dec, an_dec, if_dec.load_ready, ft_dec};
    vectors++;
    if (exp_dec_q.size() == 0) begin
      miscompares++;
      $display("FAIL dec_pins t=%0t act=%b required=<none queued>", $time, act_v);
    end else begin
      exp_v = exp_dec_q.pop_front();
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL dec_pins t=%0t seg|dp|an|rdy|ft act=%b required=%b", $time, act_v, exp_v);
      end
    end
    act_v = {seg_hex, dp_hex, an_hex, if_hex.load_ready, ft_hex};
    vectors++;
    if (exp_hex_q.size() == 0) begin
      miscompares++;
      $display("FAIL hex_pins t=%0t act=%b required=<none queued>", $time, act_v);
    end else begin
      exp_v = exp_hex_q.pop_front();
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL hex_pins t=%0t seg|dp|an|rdy|ft act=%b required=%b", $time, act_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_word(input logic [15:0] bcd, input logic [3:0] dpv);
    int waited = 0;
    @(negedge clk);
    if_dec.load_valid = 1'b1;
    if_dec.load_bcd   = bcd;
    if_dec.load_dp    = dpv;
    while (!if_dec.load_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL load_timeout word=%h ready=%b required=1 within 200 cycles", bcd, if_dec.load_ready);
    end
    @(negedge clk);
    if_dec.load_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    @(negedge clk);
    while (m_pos != p && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL scan_position pos=%0d required=%0d within 200 cycles", m_pos, p);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int nz;
    w  = 16'($urandom_range(0, 16'hFFFF));
    nz = $urandom_range(1, 4);
    return w & (16'hFFFF >> (4 * (4 - nz)));
  endfunction

  function automatic logic [3:0] rand_dp();
    return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    if_dec.load_valid = 1'b0;
    if_dec.load_bcd   = '0;
    if_dec.load_dp    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Basic word, then leading-zero blanking with and without a decimal point.
    load_word(16'h1234, 4'b0000);  wait_cycles(3 * FRAME);
    load_word(16'h0007, 4'b0000);  wait_cycles(3 * FRAME);
    load_word(16'h0007, 4'b0100);  wait_cycles(2 * FRAME);

    // Back-to-back words: the second must wait for the frame boundary.
    load_word(16'h1111, 4'b0000);
    load_word(16'h2222, 4'b0000);  wait_cycles(3 * FRAME);

    // Hex codes: blank on the decimal instance, A/E on the hex instance.
    load_word(16'h00AE, 4'b0000);  wait_cycles(2 * FRAME);

    // Reset in the middle of digit 2 with a word still pending.
    wait_pos(0);
    load_word(16'h5678, 4'b1000);
    wait_pos(2 * SD + 2);
    do_reset(1);
    wait_cycles(2 * FRAME);

    // Disable mid-slot for 10 cycles, with a word offered while dark.
    load_word(16'h4321, 4'b0001);  wait_cycles(2 * FRAME);
    wait_pos(SD + 2);
    enable = 1'b0;
    load_word(16'h9876, 4'b0010);
    wait_cycles(8);
    enable = 1'b1;
    wait_cycles(3 * FRAME);

    // Randomized traffic.
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 4))
        0, 1: load_word(rand_word(), rand_dp());
        2: begin
          @(negedge clk);
          enable = 1'b0;
          if (!m_pending && $urandom_range(0, 1) == 1) load_word(rand_word(), rand_dp());
          wait_cycles($urandom_range(1, 20));
          enable = 1'b1;
        end
        3: wait_cycles($urandom_range(1, 40));
        default: if ($urandom_range(0, 5) == 0) do_reset($urandom_range(1, 3));
      endcase
    end
    wait_cycles(2 * FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog: the run must end on its own.
  initial begin
    #500000;
    $display("FAIL watchdog t=%0t required=finish before 500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
